martian_sol_decoder: RTL and testbench

//  Inverse of the month-length lookup. Converts a 0-based sol-of-year into (month, day-of-month)
//  for the 24-month Martian calendar, using an iterative month walk with a start/done handshake.

---
 rtl/martian_pkg.sv | 21 ++
 rtl/martian_days.sv | 14 +
 rtl/martian_sol_decoder.sv | 142 ++++++++++++++
 tb/tb_martian_sol_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/martian_pkg.sv
// Shared Martian calendar types and the month-length rule used by both the
// forward (date -> sol) and inverse (sol -> date) paths.
package martian_pkg;

  localparam int NMONTH    = 24;
  localparam int SOL_W     = 10;
  localparam int YEAR_SOLS = 668;

  typedef logic [4:0] month_t;

  typedef enum logic [1:0] {IDLE, WALK, FAULT} dec_state_t;

  // Every sixth month is short; the last month regains its sol in a leap year.
  function automatic logic [4:0] month_len(month_t m, logic ly);
    if ((m == month_t'(NMONTH - 1)) && ly) begin
      return 5'd28;
    end
    return ((m % 5'd6) == 5'd5) ? 5'd27 : 5'd28;
  endfunction

endpackage

// File: rtl/martian_days.sv
// Month-length decode: flags whether month M is a 27- or 28-sol month.
module martian_days
  import martian_pkg::*;
(
  input  month_t M,
  input  logic   LY,
  output logic   D27,
  output logic   D28
);

  assign D27 = (month_len(M, LY) == 5'd27);
  assign D28 = (month_len(M, LY) == 5'd28);

endmodule

// File: rtl/martian_sol_decoder.sv
// Converts a 0-based sol-of-year into (month, day) by walking months one per
// clock, subtracting each month's length until the remainder fits.
module martian_sol_decoder
  import martian_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SOL_W-1:0] sol,
  input  logic             LY,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [4:0]       month,
  output logic [4:0]       day
);

  localparam logic [SOL_W-1:0] LAST_SOL = SOL_W'(YEAR_SOLS - 1);

  dec_state_t       state_q, state_d;
  logic [SOL_W-1:0] rem_q, rem_d;
  month_t           mcnt_q, mcnt_d;
  logic             ly_q, ly_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  month_t           month_q, month_d;
  logic [4:0]       day_q, day_d;

  logic             d27, d28;
  logic             len_ok;
  logic [SOL_W-1:0] len;
  logic [SOL_W-1:0] limit;

  martian_days u_days (
    .M   (mcnt_q),
    .LY  (ly_q),
    .D27 (d27),
    .D28 (d28)
  );

  // Exactly one of the two flags must be set; anything else is treated as a fault.
  always_comb begin
    len    = SOL_W'(28);
    len_ok = 1'b1;
    case ({d28, d27})
      2'b01:   len = SOL_W'(27);
      2'b10:   len = SOL_W'(28);
      default: len_ok = 1'b0;
    endcase
  end

  assign limit = LAST_SOL + SOL_W'(LY);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mcnt_d  = mcnt_q;
    ly_d    = ly_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    month_d = month_q;
    day_d   = day_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (sol <= limit) begin
            state_d = WALK;
            rem_d   = sol;
            ly_d    = LY;
            mcnt_d  = '0;
          end else begin
            state_d = FAULT;
          end
        end
      end
      WALK: begin
        if (!len_ok) begin
          state_d = FAULT;
          busy_d  = 1'b1;
        end else if (rem_q < len) begin
          state_d = IDLE;
          month_d = mcnt_q;
          day_d   = rem_q[4:0] + 5'd1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (mcnt_q == month_t'(NMONTH - 1)) begin
          // Remainder left over after the last month: cannot happen for an in-range sol.
          state_d = FAULT;
          busy_d  = 1'b1;
        end else begin
          rem_d  = rem_q - len;
          mcnt_d = mcnt_q + 5'd1;
          busy_d = 1'b1;
        end
      end
      FAULT: begin
        state_d = IDLE;
        done_d  = 1'b1;
        err_d   = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      mcnt_q  <= '0;
      ly_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      month_q <= '0;
      day_q   <= 5'd1;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mcnt_q  <= mcnt_d;
      ly_q    <= ly_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      month_q <= month_d;
      day_q   <= day_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign month = month_q;
  assign day   = day_q;

endmodule

// File: tb/tb_martian_sol_decoder.sv
// Directed-vector, sequence and exhaustive-sweep bench for martian_sol_decoder.
module tb_martian_sol_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] sol = '0;
  logic       LY = 1'b0;
  logic       busy, done, err;
  logic [4:0] month, day;

  int checks = 0;
  int failures = 0;
  logic done_prev = 1'b0;
  int last_m = 0;
  int last_d = 1;

  typedef struct {
    logic [9:0] sol;
    logic       ly;
    int         err;
    int         month;
    int         day;
    int         lat;
  } vec_t;

  vec_t vecs[14];

  martian_sol_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sol   (sol),
    .LY    (LY),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .month (month),
    .day   (day)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Handshake properties watched every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (err && !done) begin
        failures++;
        $display("FAIL err_without_done: err=%0d done=%0d", err, done);
      end else if (busy && done) begin
        failures++;
        $display("FAIL busy_with_done: busy=%0d done=%0d", busy, done);
      end else if (done && done_prev) begin
        failures++;
        $display("FAIL done_two_cycles: done=%0d prev=%0d", done, done_prev);
      end
    end
    done_prev = rst_n ? done : 1'b0;
  end

  // Independent reference: subtract month lengths until the remainder fits.
  function automatic void model(input int s, input int l, output int e, output int m, output int d);
    int rem;
    int len;
    rem = s;
    e = (s > 667 + l) ? 1 : 0;
    m = 0;
    d = 0;
    if (e == 1) return;
    for (int k = 0; k < 24; k++) begin
      len = ((k % 6 == 5) && !(k == 23 && l == 1)) ? 27 : 28;
      if (rem < len) begin
        m = k;
        d = rem + 1;
        return;
      end
      rem -= len;
    end
    e = 1;
  endfunction

  // Caller is 1 time unit after a rising edge; E0 is the next edge.
  task automatic do_req(input logic [9:0] s, input logic l, output int lat, output int busy_cnt,
                        output int e, output int m, output int d);
    sol = s;
    LY = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sol = 10'd5;
    lat = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cnt++;
    end
    e = int'(err);
    m = int'(month);
    d = int'(day);
    $display("req sol=%0d ly=%0d -> err=%0d month=%0d day=%0d lat=%0d", s, l, e, m, d, lat);
  endtask

  task automatic run_check(input string tag, input logic [9:0] s, input logic l,
                           input int xe, input int xm, input int xd, input int xlat);
    int lat, bc, e, m, d;
    do_req(s, l, lat, bc, e, m, d);
    chk({tag, "_lat"}, lat, xlat);
    chk({tag, "_err"}, e, xe);
    chk({tag, "_month"}, m, xm);
    chk({tag, "_day"}, d, xd);
    chk({tag, "_busy_cycles"}, bc, (xe == 1) ? 0 : xlat - 1);
  endtask

  initial begin
    int xe, xm, xd;

    vecs[0]  = '{10'd0,    1'b0, 0, 0,  1,  1};
    vecs[1]  = '{10'd27,   1'b0, 0, 0,  28, 1};
    vecs[2]  = '{10'd28,   1'b0, 0, 1,  1,  2};
    vecs[3]  = '{10'd139,  1'b0, 0, 4,  28, 5};
    vecs[4]  = '{10'd140,  1'b0, 0, 5,  1,  6};
    vecs[5]  = '{10'd166,  1'b0, 0, 5,  27, 6};
    vecs[6]  = '{10'd167,  1'b0, 0, 6,  1,  7};
    vecs[7]  = '{10'd667,  1'b0, 0, 23, 27, 24};
    vecs[8]  = '{10'd668,  1'b1, 0, 23, 28, 24};
    vecs[9]  = '{10'd668,  1'b0, 1, 23, 28, 1};
    vecs[10] = '{10'd1023, 1'b1, 1, 23, 28, 1};
    vecs[11] = '{10'd669,  1'b1, 1, 23, 28, 1};
    vecs[12] = '{10'd400,  1'b0, 0, 14, 11, 15};
    vecs[13] = '{10'd0,    1'b1, 0, 0,  1,  1};

    // Reset values, both during and after reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_month", int'(month), 0);
    chk("rst_day", int'(day), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_done", int'(done), 0);
    chk("idle_day", int'(day), 1);

    // Back-to-back: each request is launched in the done cycle of the previous one.
    for (int i = 0; i < 14; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].sol, vecs[i].ly,
                vecs[i].err, vecs[i].month, vecs[i].day, vecs[i].lat);
    end

    // start held high: sol=60 (month 2, day 5, 3 walk cycles) accepted every 4th edge;
    // values offered while busy would be visible if they were ever accepted.
    sol = 10'd60;
    LY = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_done_c%0d", c), int'(done), (c % 4 == 3) ? 1 : 0);
      chk($sformatf("hold_err_c%0d", c), int'(err), 0);
      if (c % 4 == 3) begin
        chk($sformatf("hold_month_c%0d", c), int'(month), 2);
        chk($sformatf("hold_day_c%0d", c), int'(day), 5);
        $display("req hold c=%0d -> month=%0d day=%0d", c, month, day);
      end
      if ((c + 1) % 4 == 0) sol = 10'd60;
      else sol = (c % 2 == 1) ? 10'd1023 : 10'd5;
    end
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_quiet_c%0d", c), int'(done), 0);
    end

    // Reset in the middle of a walk of sol=400.
    sol = 10'd400;
    LY = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_month", int'(month), 0);
    chk("midrst_day", int'(day), 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_nodone_c%0d", c), int'(done), 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_done", int'(done), 0);
    run_check("postrst_400", 10'd400, 1'b0, 0, 14, 11, 15);
    last_m = 14;
    last_d = 11;

    // Exhaustive sweep against the reference model.
    for (int l = 0; l < 2; l++) begin
      for (int s = 0; s <= 669; s++) begin
        model(s, l, xe, xm, xd);
        if (xe == 1) begin
          run_check($sformatf("sweep_ly%0d_sol%0d", l, s), 10'(s), l[0], 1, last_m, last_d, 1);
        end else begin
          run_check($sformatf("sweep_ly%0d_sol%0d", l, s), 10'(s), l[0], 0, xm, xd, xm + 1);
          last_m = xm;
          last_d = xd;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
